// File: rtl/axi_lite_master_engine.sv
// Single-outstanding AXI4-Lite master: turns a command/response register-access
// interface into AXI4-Lite reads and writes, and keeps completion/error counters.
module axi_lite_master_engine #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              axil_aclk,
    input  logic              axil_areset,
    // command side
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    // response side
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [31:0]       rsp_rdata,
    output logic [1:0]        rsp_resp,
    // AW channel
    output logic              m_axil_awvalid,
    output logic [ADDR_W-1:0] m_axil_awaddr,
    input  logic              m_axil_awready,
    // W channel
    output logic              m_axil_wvalid,
    output logic [31:0]       m_axil_wdata,
    output logic [3:0]        m_axil_wstrb,
    input  logic              m_axil_wready,
    // B channel
    input  logic              m_axil_bvalid,
    input  logic [1:0]        m_axil_bresp,
    output logic              m_axil_bready,
    // AR channel
    output logic              m_axil_arvalid,
    output logic [ADDR_W-1:0] m_axil_araddr,
    input  logic              m_axil_arready,
    // R channel
    input  logic              m_axil_rvalid,
    input  logic [31:0]       m_axil_rdata,
    input  logic [1:0]        m_axil_rresp,
    output logic              m_axil_rready,
    // debug counters
    output logic [CNT_W-1:0]  wr_count,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  err_count
);

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StWrResp,
        StRdAddr,
        StRdData,
        StResp
    } state_e;

    state_e             r_state;
    state_e             w_state_next;

    logic [ADDR_W-1:0]  r_addr;
    logic [31:0]        r_wdata;
    logic               r_write;
    logic               r_aw_done;
    logic               r_w_done;
    logic [31:0]        r_rdata;
    logic [1:0]         r_resp;
    logic [CNT_W-1:0]   r_wr_count;
    logic [CNT_W-1:0]   r_rd_count;
    logic [CNT_W-1:0]   r_err_count;

    logic               w_accept;
    logic               w_aw_hs;
    logic               w_w_hs;
    logic               w_b_hs;
    logic               w_r_hs;
    logic               w_unused_addr_lsb;

    // Handshakes decoded from state and registers so no valid feeds back into itself.
    assign w_accept = (r_state == StIdle) && req_valid;
    assign w_aw_hs  = (r_state == StWr) && !r_aw_done && m_axil_awready;
    assign w_w_hs   = (r_state == StWr) && !r_w_done && m_axil_wready;
    assign w_b_hs   = (r_state == StWrResp) && m_axil_bvalid;
    assign w_r_hs   = (r_state == StRdData) && m_axil_rvalid;

    // Byte lanes below word granularity are ignored; the address is word-aligned.
    assign w_unused_addr_lsb = ^req_addr[1:0];

    assign m_axil_awaddr = r_addr;
    assign m_axil_araddr = r_addr;
    assign m_axil_wdata  = r_wdata;
    assign m_axil_wstrb  = 4'hF;

    assign rsp_write = r_write;
    assign rsp_rdata = r_rdata;
    assign rsp_resp  = r_resp;

    assign wr_count  = r_wr_count;
    assign rd_count  = r_rd_count;
    assign err_count = r_err_count;

    // Next-state decode and state-derived handshake outputs.
    always_comb begin
        w_state_next   = r_state;
        req_ready      = 1'b0;
        rsp_valid      = 1'b0;
        m_axil_awvalid = 1'b0;
        m_axil_wvalid  = 1'b0;
        m_axil_bready  = 1'b0;
        m_axil_arvalid = 1'b0;
        m_axil_rready  = 1'b0;
        unique case (r_state)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_next = req_write ? StWr : StRdAddr;
                end
            end
            StWr: begin
                m_axil_awvalid = !r_aw_done;
                m_axil_wvalid  = !r_w_done;
                if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
                    w_state_next = StWrResp;
                end
            end
            StWrResp: begin
                m_axil_bready = 1'b1;
                if (m_axil_bvalid) begin
                    w_state_next = StResp;
                end
            end
            StRdAddr: begin
                m_axil_arvalid = 1'b1;
                if (m_axil_arready) begin
                    w_state_next = StRdData;
                end
            end
            StRdData: begin
                m_axil_rready = 1'b1;
                if (m_axil_rvalid) begin
                    w_state_next = StResp;
                end
            end
            StResp: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // State, command capture, response capture and counters.
    always_ff @(posedge axil_aclk) begin
        if (axil_areset) begin
            r_state     <= StIdle;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_write     <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_rdata     <= '0;
            r_resp      <= '0;
            r_wr_count  <= '0;
            r_rd_count  <= '0;
            r_err_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_addr    <= {req_addr[ADDR_W-1:2], 2'b00};
                r_wdata   <= req_wdata;
                r_write   <= req_write;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end
            if (w_aw_hs) begin
                r_aw_done <= 1'b1;
            end
            if (w_w_hs) begin
                r_w_done <= 1'b1;
            end
            if (w_b_hs) begin
                r_rdata    <= '0;
                r_resp     <= m_axil_bresp;
                r_wr_count <= r_wr_count + CNT_W'(1);
                if (m_axil_bresp != 2'b00) begin
                    r_err_count <= r_err_count + CNT_W'(1);
                end
            end
            if (w_r_hs) begin
                r_rdata    <= m_axil_rdata;
                r_resp     <= m_axil_rresp;
                r_rd_count <= r_rd_count + CNT_W'(1);
                if (m_axil_rresp != 2'b00) begin
                    r_err_count <= r_err_count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_master_engine.sv
// Directed bench for axi_lite_master_engine with a small AXI4-Lite register slave model.
module tb_axi_lite_master_engine;

    localparam int ADDR_W = 32;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid, req_ready, req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid, rsp_ready, rsp_write;
    logic [31:0]       rsp_rdata;
    logic [1:0]        rsp_resp;
    logic              awvalid, awready, wvalid, wready, bvalid, bready;
    logic              arvalid, arready, rvalid, rready;
    logic [ADDR_W-1:0] awaddr, araddr;
    logic [31:0]       wdata, rdata;
    logic [3:0]        wstrb;
    logic [1:0]        bresp, rresp;
    logic [CNT_W-1:0]  wr_count, rd_count, err_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    axi_lite_master_engine #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .axil_aclk      (clk),
        .axil_areset    (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_write      (rsp_write),
        .rsp_rdata      (rsp_rdata),
        .rsp_resp       (rsp_resp),
        .m_axil_awvalid (awvalid),
        .m_axil_awaddr  (awaddr),
        .m_axil_awready (awready),
        .m_axil_wvalid  (wvalid),
        .m_axil_wdata   (wdata),
        .m_axil_wstrb   (wstrb),
        .m_axil_wready  (wready),
        .m_axil_bvalid  (bvalid),
        .m_axil_bresp   (bresp),
        .m_axil_bready  (bready),
        .m_axil_arvalid (arvalid),
        .m_axil_araddr  (araddr),
        .m_axil_arready (arready),
        .m_axil_rvalid  (rvalid),
        .m_axil_rdata   (rdata),
        .m_axil_rresp   (rresp),
        .m_axil_rready  (rready),
        .wr_count       (wr_count),
        .rd_count       (rd_count),
        .err_count      (err_count)
    );

    // ---------------- slave model: 12-bit address space of 32-bit registers ----------------
    logic [31:0] mem [0:1023];
    int          aw_delay   = 0;
    int          w_delay    = 0;
    int          aw_wait, w_wait;
    logic        r_hold     = 1'b0;
    logic [1:0]  r_resp_cfg = 2'b00;
    logic [1:0]  b_resp_cfg = 2'b00;
    logic        s_aw_got, s_w_got;
    logic [31:0] s_awaddr, s_wdata;
    int          b_acc = 0;
    logic [31:0] last_araddr;
    logic        aw_hs, w_hs, s_aw_g, s_w_g;
    logic [31:0] s_addr_n, s_data_n;

    assign awready  = awvalid && (aw_wait >= aw_delay);
    assign wready   = wvalid && (w_wait >= w_delay);
    assign arready  = arvalid;
    assign aw_hs    = awvalid && awready;
    assign w_hs     = wvalid && wready;
    assign s_aw_g   = s_aw_got || aw_hs;
    assign s_w_g    = s_w_got || w_hs;
    assign s_addr_n = aw_hs ? awaddr : s_awaddr;
    assign s_data_n = w_hs ? wdata : s_wdata;

    // Ready-delay counters for AW and W.
    always @(posedge clk) begin
        if (rst) begin
            aw_wait <= 0;
            w_wait  <= 0;
        end else begin
            aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
            w_wait  <= (wvalid && !wready) ? w_wait + 1 : 0;
        end
    end

    // Write path: once both AW and W are in, store and answer on B.
    always @(posedge clk) begin
        if (rst) begin
            s_aw_got <= 1'b0;
            s_w_got  <= 1'b0;
            bvalid   <= 1'b0;
            bresp    <= 2'b00;
            s_awaddr <= '0;
            s_wdata  <= '0;
        end else begin
            if (bvalid && bready) begin
                bvalid <= 1'b0;
                b_acc  <= b_acc + 1;
            end
            if (s_aw_g && s_w_g && !bvalid) begin
                mem[s_addr_n[11:2]] <= s_data_n;
                bvalid   <= 1'b1;
                bresp    <= b_resp_cfg;
                s_aw_got <= 1'b0;
                s_w_got  <= 1'b0;
            end else begin
                s_aw_got <= s_aw_g;
                s_w_got  <= s_w_g;
                if (aw_hs) s_awaddr <= awaddr;
                if (w_hs) s_wdata <= wdata;
            end
        end
    end

    // Read path: R follows the AR handshake by one cycle unless held off.
    always @(posedge clk) begin
        if (rst) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            rresp  <= 2'b00;
        end else begin
            if (rvalid && rready) rvalid <= 1'b0;
            if (arvalid && arready) begin
                last_araddr <= araddr;
                if (!r_hold) begin
                    rvalid <= 1'b1;
                    rdata  <= mem[araddr[11:2]];
                    rresp  <= r_resp_cfg;
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one command, wait for its response, hold rsp_ready low for 'hold' cycles.
    task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          input int hold, output logic [31:0] rd, output logic [1:0] rs,
                          output int lat);
        int n;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check_eq("accept_timeout", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) check_eq("rsp_timeout", 32'(rsp_valid), 32'd1);
        rd = rsp_rdata;
        rs = rsp_resp;
        check_eq("rsp_write", 32'(rsp_write), 32'(wr));
        for (int i = 0; i < hold; i++) begin
            check_eq("hold_rdata", rsp_rdata, rd);
            check_eq("hold_resp", 32'(rsp_resp), 32'(rs));
            check_eq("hold_valid", 32'(rsp_valid), 32'd1);
            check_eq("hold_req_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq("req_ready_after_rsp", 32'(req_ready), 32'd1);
    endtask

    logic [31:0] t_rd;
    logic [1:0]  t_rs;
    int          t_lat;
    int          b0;

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // reset state
        check_eq("rst_req_ready", 32'(req_ready), 32'd1);
        check_eq("rst_valids", {27'd0, awvalid, wvalid, arvalid, rsp_valid, 1'b0}, 32'd0);
        check_eq("rst_readies", {30'd0, bready, rready}, 32'd0);
        check_eq("rst_wstrb", 32'(wstrb), 32'hF);
        check_eq("rst_counts", {20'd0, wr_count, rd_count, err_count}, 32'd0);
        check_eq("rst_rsp", rsp_rdata, 32'd0);

        // write then read back, zero-wait slave
        do_txn(1'b1, 32'h0000_0010, 32'hCAFE_F00D, 0, t_rd, t_rs, t_lat);
        check_eq("wr_lat", 32'(t_lat), 32'd3);
        check_eq("wr_rdata_zero", t_rd, 32'd0);
        check_eq("wr_resp", 32'(t_rs), 32'd0);
        check_eq("wr_count1", 32'(wr_count), 32'd1);
        do_txn(1'b0, 32'h0000_0010, 32'h0, 0, t_rd, t_rs, t_lat);
        check_eq("rd_lat", 32'(t_lat), 32'd3);
        check_eq("rd_data", t_rd, 32'hCAFE_F00D);
        check_eq("rd_resp", 32'(t_rs), 32'd0);
        check_eq("rd_count1", 32'(rd_count), 32'd1);

        // skewed AW/W: awready 5 cycles after wready
        aw_delay = 5;
        b0 = b_acc;
        @(negedge clk);
        check_eq("skew_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h0000_0020;
        req_wdata = 32'h1111_2222;
        @(negedge clk);
        req_valid = 1'b0;
        check_eq("skew_c1_valids", {30'd0, awvalid, wvalid}, 32'd3);
        for (int c = 2; c <= 6; c++) begin
            @(negedge clk);
            check_eq("skew_wvalid_low", 32'(wvalid), 32'd0);
            check_eq("skew_awvalid_high", 32'(awvalid), 32'd1);
            check_eq("skew_awaddr", awaddr, 32'h0000_0020);
            check_eq("skew_bready_low", 32'(bready), 32'd0);
        end
        @(negedge clk);
        check_eq("skew_bready", 32'(bready), 32'd1);
        check_eq("skew_awvalid_done", 32'(awvalid), 32'd0);
        @(negedge clk);
        check_eq("skew_rsp_valid", 32'(rsp_valid), 32'd1);
        check_eq("skew_rsp_rdata", rsp_rdata, 32'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("skew_one_b", 32'(b_acc - b0), 32'd1);
        check_eq("wr_count2", 32'(wr_count), 32'd2);
        aw_delay = 0;

        // error response with backpressure
        do_txn(1'b1, 32'h0000_0FFC, 32'h1234_5678, 0, t_rd, t_rs, t_lat);
        r_resp_cfg = 2'b10;
        do_txn(1'b0, 32'h0000_0FFC, 32'h0, 4, t_rd, t_rs, t_lat);
        r_resp_cfg = 2'b00;
        check_eq("err_rdata", t_rd, 32'h1234_5678);
        check_eq("err_resp", 32'(t_rs), 32'd2);
        check_eq("err_count1", 32'(err_count), 32'd1);
        check_eq("rd_count2", 32'(rd_count), 32'd2);

        // address alignment
        do_txn(1'b0, 32'h0000_0023, 32'h0, 0, t_rd, t_rs, t_lat);
        check_eq("align_araddr", last_araddr, 32'h0000_0020);
        check_eq("align_rdata", t_rd, 32'h1111_2222);

        // reset during RD_DATA
        r_hold = 1'b1;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h0000_0010;
        @(negedge clk);
        req_valid = 1'b0;
        check_eq("mid_arvalid", 32'(arvalid), 32'd1);
        @(negedge clk);
        check_eq("mid_rready", 32'(rready), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        r_hold = 1'b0;
        check_eq("mid_rready_low", 32'(rready), 32'd0);
        check_eq("mid_req_ready", 32'(req_ready), 32'd1);
        check_eq("mid_counts", {20'd0, wr_count, rd_count, err_count}, 32'd0);

        // counter wrap with 4-bit counters
        for (int i = 0; i < 17; i++) begin
            do_txn(1'b1, 32'(i * 4), 32'(i), 0, t_rd, t_rs, t_lat);
        end
        check_eq("wrap_wr_count", 32'(wr_count), 32'd1);
        check_eq("wrap_rd_count", 32'(rd_count), 32'd0);
        check_eq("wrap_err_count", 32'(err_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
